// File: rtl/bp_gshare_btb.sv
// Fetch-stage branch predictor: tagged direct-mapped BTB plus gshare PHT with a
// speculatively shifted global history that is repaired when E resolves a branch.
module bp_gshare_btb #(
  parameter int BTB_ENTRIES = 64,
  parameter int TAG_BITS    = 16,
  parameter int PHT_BITS    = 8,
  parameter int GHR_BITS    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         pc_F,
  input  logic [31:0]         pc4_F,
  input  logic                stall_F,
  output logic [31:0]         pc_next,
  output logic                pred_taken_F,
  output logic                btb_hit_F,
  output logic [GHR_BITS-1:0] ghr_F,
  input  logic                branch_E,
  input  logic                jump_E,
  input  logic                taken_E,
  input  logic                btb_hit_E,
  input  logic [GHR_BITS-1:0] ghr_E,
  input  logic [31:0]         pc_E,
  input  logic [31:0]         pc4_E,
  input  logic [31:0]         pc_target_E,
  input  logic [31:0]         pc_D,
  output logic                flush,
  output logic [31:0]         pc_restore
);

  localparam int IDX         = $clog2(BTB_ENTRIES);
  localparam int PHT_ENTRIES = 1 << PHT_BITS;

  logic                btb_valid   [BTB_ENTRIES];
  logic [TAG_BITS-1:0] btb_tag     [BTB_ENTRIES];
  logic [31:0]         btb_target  [BTB_ENTRIES];
  logic                btb_is_jump [BTB_ENTRIES];
  logic [1:0]          pht         [PHT_ENTRIES];
  logic [GHR_BITS-1:0] ghr_q;
  logic [GHR_BITS-1:0] ghr_d;

  logic [IDX-1:0]      idx_F;
  logic [TAG_BITS-1:0] tag_F;
  logic [PHT_BITS-1:0] pht_idx_F;
  logic                is_jump_F;
  logic [IDX-1:0]      idx_E;
  logic [TAG_BITS-1:0] tag_E;
  logic [PHT_BITS-1:0] pht_idx_E;
  logic [1:0]          ctr_E;
  logic [1:0]          ctr_next_E;
  logic                is_branch_E;
  logic                btb_we;
  logic [31:0]         correct_pc_E;
  logic [GHR_BITS-1:0] spec_shift;
  logic [GHR_BITS-1:0] repair_shift;
  logic                unused_bits;

  // Fetch-side lookup: BTB and PHT are read in the same cycle as pc_F.
  assign idx_F        = pc_F[IDX+1:2];
  assign tag_F        = pc_F[IDX+TAG_BITS+1:IDX+2];
  assign pht_idx_F    = pc_F[PHT_BITS+1:2] ^ PHT_BITS'(ghr_q);
  assign is_jump_F    = btb_is_jump[idx_F];
  assign btb_hit_F    = btb_valid[idx_F] & (btb_tag[idx_F] == tag_F);
  assign pred_taken_F = btb_hit_F & (is_jump_F | pht[pht_idx_F][1]);
  assign pc_next      = pred_taken_F ? btb_target[idx_F] : pc4_F;
  assign ghr_F        = ghr_q;

  // A branch flagged together with a jump is resolved as a jump.
  assign is_branch_E  = branch_E & ~jump_E;
  assign idx_E        = pc_E[IDX+1:2];
  assign tag_E        = pc_E[IDX+TAG_BITS+1:IDX+2];
  assign pht_idx_E    = pc_E[PHT_BITS+1:2] ^ PHT_BITS'(ghr_E);
  assign ctr_E        = pht[pht_idx_E];
  assign btb_we       = jump_E | (is_branch_E & taken_E);

  assign correct_pc_E = (jump_E | taken_E) ? pc_target_E : pc4_E;
  assign flush        = (branch_E | jump_E) & (pc_D != correct_pc_E);
  assign pc_restore   = flush ? correct_pc_E : 32'h0;

  assign unused_bits  = ^{pc_F, pc_E};

  generate
    if (GHR_BITS == 1) begin : g_ghr1
      assign spec_shift   = pred_taken_F;
      assign repair_shift = taken_E;
    end else begin : g_ghrn
      assign spec_shift   = {ghr_q[GHR_BITS-2:0], pred_taken_F};
      assign repair_shift = {ghr_E[GHR_BITS-2:0], taken_E};
    end
  endgenerate

  // E-stage repair outranks the fetch-side speculative shift.
  always_comb begin
    ghr_d = ghr_q;
    if (is_branch_E & (flush | ~btb_hit_E)) begin
      ghr_d = repair_shift;
    end else if (jump_E & flush) begin
      ghr_d = ghr_E;
    end else if (~stall_F & btb_hit_F & ~is_jump_F) begin
      ghr_d = spec_shift;
    end
  end

  always_comb begin
    ctr_next_E = ctr_E;
    if (taken_E) begin
      if (ctr_E != 2'b11) ctr_next_E = ctr_E + 2'b01;
    end else begin
      if (ctr_E != 2'b00) ctr_next_E = ctr_E - 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PHT_ENTRIES; i++) pht[i] <= 2'b01;
    end else if (is_branch_E) begin
      pht[pht_idx_E] <= ctr_next_E;
    end
  end

  // Only the valid bits need reset; payload is ignored while invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BTB_ENTRIES; i++) btb_valid[i] <= 1'b0;
    end else if (btb_we) begin
      btb_valid[idx_E] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (btb_we) begin
      btb_tag[idx_E]     <= tag_E;
      btb_target[idx_E]  <= pc_target_E;
      btb_is_jump[idx_E] <= jump_E;
    end
  end

endmodule

// File: tb/tb_bp_gshare_btb.sv
// Self-checking bench for bp_gshare_btb: per-scenario tasks drive a step table
// and compare DUT outputs against a scoreboard of hand-derived expectations.
module tb_bp_gshare_btb;

  localparam int GB = 8;

  typedef struct packed {
    logic [31:0] pc_f;
    logic        stall;
    logic        br;
    logic        jmp;
    logic        tkn;
    logic        hit_e;
    logic [7:0]  ghr_e;
    logic [31:0] pc_e;
    logic [31:0] tgt;
    logic [31:0] pc_d;
  } stim_t;

  typedef struct packed {
    logic [31:0] nxt;
    logic        tk;
    logic        hit;
    logic [7:0]  ghr;
    logic        fl;
    logic [31:0] rst;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic [31:0]   pc_F, pc4_F;
  logic          stall_F;
  logic [31:0]   pc_next;
  logic          pred_taken_F, btb_hit_F;
  logic [GB-1:0] ghr_F;
  logic          branch_E, jump_E, taken_E, btb_hit_E;
  logic [GB-1:0] ghr_E;
  logic [31:0]   pc_E, pc4_E, pc_target_E, pc_D;
  logic          flush;
  logic [31:0]   pc_restore;

  exp_t  sb[$];
  string sb_name[$];
  int    checks = 0;
  int    errors = 0;

  bp_gshare_btb #(.BTB_ENTRIES(64), .TAG_BITS(16), .PHT_BITS(8), .GHR_BITS(GB)) dut (
    .clk(clk), .rst_n(rst_n), .pc_F(pc_F), .pc4_F(pc4_F), .stall_F(stall_F),
    .pc_next(pc_next), .pred_taken_F(pred_taken_F), .btb_hit_F(btb_hit_F), .ghr_F(ghr_F),
    .branch_E(branch_E), .jump_E(jump_E), .taken_E(taken_E), .btb_hit_E(btb_hit_E),
    .ghr_E(ghr_E), .pc_E(pc_E), .pc4_E(pc4_E), .pc_target_E(pc_target_E), .pc_D(pc_D),
    .flush(flush), .pc_restore(pc_restore)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t mk_stim(input logic [31:0] pcf, input logic stall,
                                    input logic br, input logic jmp, input logic tkn,
                                    input logic hite, input logic [7:0] ghre,
                                    input logic [31:0] pce, input logic [31:0] tgt,
                                    input logic [31:0] pcd);
    stim_t s;
    s.pc_f = pcf; s.stall = stall; s.br = br; s.jmp = jmp; s.tkn = tkn;
    s.hit_e = hite; s.ghr_e = ghre; s.pc_e = pce; s.tgt = tgt; s.pc_d = pcd;
    return s;
  endfunction

  function automatic stim_t mk_idle(input logic [31:0] pcf, input logic stall);
    return mk_stim(pcf, stall, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 32'h0, 32'h0);
  endfunction

  function automatic exp_t mk_exp(input logic [31:0] nxt, input logic tk, input logic hit,
                                  input logic [7:0] ghr, input logic fl, input logic [31:0] rst);
    exp_t e;
    e.nxt = nxt; e.tk = tk; e.hit = hit; e.ghr = ghr; e.fl = fl; e.rst = rst;
    return e;
  endfunction

  task automatic drive(input stim_t s);
    pc_F        = s.pc_f;
    pc4_F       = s.pc_f + 32'd4;
    stall_F     = s.stall;
    branch_E    = s.br;
    jump_E      = s.jmp;
    taken_E     = s.tkn;
    btb_hit_E   = s.hit_e;
    ghr_E       = s.ghr_e;
    pc_E        = s.pc_e;
    pc4_E       = s.pc_e + 32'd4;
    pc_target_E = s.tgt;
    pc_D        = s.pc_d;
  endtask

  task automatic test_reset();
    exp_t got, want;
    string nm;
    rst_n = 1'b0;
    drive(mk_idle(32'h100, 1'b0));
    sb.push_back(mk_exp(32'h104, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0));
    sb_name.push_back("reset");
    @(negedge clk);
    #2;
    got  = {pc_next, pred_taken_F, btb_hit_F, ghr_F, flush, pc_restore};
    want = sb.pop_front();
    nm   = sb_name.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got nxt=%h tk=%b hit=%b ghr=%h fl=%b rst=%h, need nxt=%h tk=%b hit=%b ghr=%h fl=%b rst=%h",
               nm, got.nxt, got.tk, got.hit, got.ghr, got.fl, got.rst,
               want.nxt, want.tk, want.hit, want.ghr, want.fl, want.rst);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_jump();
    stim_t st[$];
    exp_t  ex[$];
    exp_t  got, want;
    string nm;
    st.push_back(mk_stim(32'h100, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 32'h200, 32'h400, 32'h204));
    ex.push_back(mk_exp(32'h104, 1'b0, 1'b0, 8'h00, 1'b1, 32'h400));
    st.push_back(mk_idle(32'h200, 1'b0));
    ex.push_back(mk_exp(32'h400, 1'b1, 1'b1, 8'h00, 1'b0, 32'h0));
    st.push_back(mk_idle(32'h200, 1'b1));
    ex.push_back(mk_exp(32'h400, 1'b1, 1'b1, 8'h00, 1'b0, 32'h0));
    foreach (st[i]) begin
      @(negedge clk);
      drive(st[i]);
      sb.push_back(ex[i]);
      sb_name.push_back($sformatf("jump_%0d", i));
      #2;
      got  = {pc_next, pred_taken_F, btb_hit_F, ghr_F, flush, pc_restore};
      want = sb.pop_front();
      nm   = sb_name.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL %s: got nxt=%h tk=%b hit=%b ghr=%h fl=%b rst=%h, need nxt=%h tk=%b hit=%b ghr=%h fl=%b rst=%h",
                 nm, got.nxt, got.tk, got.hit, got.ghr, got.fl, got.rst,
                 want.nxt, want.tk, want.hit, want.ghr, want.fl, want.rst);
      end
    end
  endtask

  task automatic test_branch_train();
    stim_t st[$];
    exp_t  ex[$];
    exp_t  got, want;
    string nm;
    st.push_back(mk_stim(32'h100, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h5A, 32'h300, 32'h380, 32'h380));
    ex.push_back(mk_exp(32'h104, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0));
    st.push_back(mk_stim(32'h100, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h5A, 32'h300, 32'h380, 32'h380));
    ex.push_back(mk_exp(32'h104, 1'b0, 1'b0, 8'hB5, 1'b0, 32'h0));
    st.push_back(mk_stim(32'h100, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h5A, 32'h208, 32'h500, 32'h20C));
    ex.push_back(mk_exp(32'h104, 1'b0, 1'b0, 8'hB5, 1'b1, 32'h500));
    st.push_back(mk_idle(32'h300, 1'b1));
    ex.push_back(mk_exp(32'h380, 1'b1, 1'b1, 8'h5A, 1'b0, 32'h0));
    st.push_back(mk_idle(32'h300, 1'b0));
    ex.push_back(mk_exp(32'h380, 1'b1, 1'b1, 8'h5A, 1'b0, 32'h0));
    st.push_back(mk_idle(32'h100, 1'b1));
    ex.push_back(mk_exp(32'h104, 1'b0, 1'b0, 8'hB5, 1'b0, 32'h0));
    foreach (st[i]) begin
      @(negedge clk);
      drive(st[i]);
      sb.push_back(ex[i]);
      sb_name.push_back($sformatf("branch_train_%0d", i));
      #2;
      got  = {pc_next, pred_taken_F, btb_hit_F, ghr_F, flush, pc_restore};
      want = sb.pop_front();
      nm   = sb_name.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL %s: got nxt=%h tk=%b hit=%b ghr=%h fl=%b rst=%h, need nxt=%h tk=%b hit=%b ghr=%h fl=%b rst=%h",
                 nm, got.nxt, got.tk, got.hit, got.ghr, got.fl, got.rst,
                 want.nxt, want.tk, want.hit, want.ghr, want.fl, want.rst);
      end
    end
  endtask

  task automatic test_mispredict();
    stim_t st[$];
    exp_t  ex[$];
    exp_t  got, want;
    string nm;
    st.push_back(mk_stim(32'h300, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A, 32'h300, 32'h380, 32'h380));
    ex.push_back(mk_exp(32'h304, 1'b0, 1'b1, 8'hB5, 1'b1, 32'h304));
    st.push_back(mk_stim(32'h100, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h5A, 32'h208, 32'h500, 32'h20C));
    ex.push_back(mk_exp(32'h104, 1'b0, 1'b0, 8'hB4, 1'b1, 32'h500));
    st.push_back(mk_idle(32'h300, 1'b1));
    ex.push_back(mk_exp(32'h380, 1'b1, 1'b1, 8'h5A, 1'b0, 32'h0));
    st.push_back(mk_stim(32'h300, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A, 32'h300, 32'h380, 32'h304));
    ex.push_back(mk_exp(32'h380, 1'b1, 1'b1, 8'h5A, 1'b0, 32'h0));
    st.push_back(mk_idle(32'h300, 1'b1));
    ex.push_back(mk_exp(32'h304, 1'b0, 1'b1, 8'h5A, 1'b0, 32'h0));
    foreach (st[i]) begin
      @(negedge clk);
      drive(st[i]);
      sb.push_back(ex[i]);
      sb_name.push_back($sformatf("mispredict_%0d", i));
      #2;
      got  = {pc_next, pred_taken_F, btb_hit_F, ghr_F, flush, pc_restore};
      want = sb.pop_front();
      nm   = sb_name.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL %s: got nxt=%h tk=%b hit=%b ghr=%h fl=%b rst=%h, need nxt=%h tk=%b hit=%b ghr=%h fl=%b rst=%h",
                 nm, got.nxt, got.tk, got.hit, got.ghr, got.fl, got.rst,
                 want.nxt, want.tk, want.hit, want.ghr, want.fl, want.rst);
      end
    end
  endtask

  task automatic test_saturation();
    stim_t st[$];
    exp_t  ex[$];
    exp_t  got, want;
    string nm;
    for (int k = 0; k < 6; k++) begin
      st.push_back(mk_stim(32'h100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A, 32'h40, 32'h600, 32'h44));
      ex.push_back(mk_exp(32'h104, 1'b0, 1'b0, 8'h5A, 1'b0, 32'h0));
    end
    for (int k = 0; k < 2; k++) begin
      st.push_back(mk_stim(32'h100, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h5A, 32'h40, 32'h600, 32'h600));
      ex.push_back(mk_exp(32'h104, 1'b0, 1'b0, 8'h5A, 1'b0, 32'h0));
    end
    st.push_back(mk_idle(32'h40, 1'b1));
    ex.push_back(mk_exp(32'h600, 1'b1, 1'b1, 8'h5A, 1'b0, 32'h0));
    foreach (st[i]) begin
      @(negedge clk);
      drive(st[i]);
      sb.push_back(ex[i]);
      sb_name.push_back($sformatf("saturation_%0d", i));
      #2;
      got  = {pc_next, pred_taken_F, btb_hit_F, ghr_F, flush, pc_restore};
      want = sb.pop_front();
      nm   = sb_name.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL %s: got nxt=%h tk=%b hit=%b ghr=%h fl=%b rst=%h, need nxt=%h tk=%b hit=%b ghr=%h fl=%b rst=%h",
                 nm, got.nxt, got.tk, got.hit, got.ghr, got.fl, got.rst,
                 want.nxt, want.tk, want.hit, want.ghr, want.fl, want.rst);
      end
    end
  endtask

  task automatic test_alias();
    stim_t st[$];
    exp_t  ex[$];
    exp_t  got, want;
    string nm;
    st.push_back(mk_stim(32'h100, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 32'h1000, 32'h700, 32'h700));
    ex.push_back(mk_exp(32'h104, 1'b0, 1'b0, 8'h5A, 1'b0, 32'h0));
    st.push_back(mk_stim(32'h100, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 32'h1004, 32'h740, 32'h740));
    ex.push_back(mk_exp(32'h104, 1'b0, 1'b0, 8'h5A, 1'b0, 32'h0));
    st.push_back(mk_idle(32'h1000, 1'b1));
    ex.push_back(mk_exp(32'h700, 1'b1, 1'b1, 8'h5A, 1'b0, 32'h0));
    st.push_back(mk_idle(32'h1004, 1'b1));
    ex.push_back(mk_exp(32'h740, 1'b1, 1'b1, 8'h5A, 1'b0, 32'h0));
    st.push_back(mk_idle(32'h300, 1'b1));
    ex.push_back(mk_exp(32'h304, 1'b0, 1'b0, 8'h5A, 1'b0, 32'h0));
    foreach (st[i]) begin
      @(negedge clk);
      drive(st[i]);
      sb.push_back(ex[i]);
      sb_name.push_back($sformatf("alias_%0d", i));
      #2;
      got  = {pc_next, pred_taken_F, btb_hit_F, ghr_F, flush, pc_restore};
      want = sb.pop_front();
      nm   = sb_name.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL %s: got nxt=%h tk=%b hit=%b ghr=%h fl=%b rst=%h, need nxt=%h tk=%b hit=%b ghr=%h fl=%b rst=%h",
                 nm, got.nxt, got.tk, got.hit, got.ghr, got.fl, got.rst,
                 want.nxt, want.tk, want.hit, want.ghr, want.fl, want.rst);
      end
    end
  endtask

  task automatic test_branch_and_jump();
    stim_t st[$];
    exp_t  ex[$];
    exp_t  got, want;
    string nm;
    st.push_back(mk_stim(32'h100, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h33, 32'h2000, 32'h900, 32'h2004));
    ex.push_back(mk_exp(32'h104, 1'b0, 1'b0, 8'h5A, 1'b1, 32'h900));
    st.push_back(mk_idle(32'h2000, 1'b1));
    ex.push_back(mk_exp(32'h900, 1'b1, 1'b1, 8'h33, 1'b0, 32'h0));
    foreach (st[i]) begin
      @(negedge clk);
      drive(st[i]);
      sb.push_back(ex[i]);
      sb_name.push_back($sformatf("branch_and_jump_%0d", i));
      #2;
      got  = {pc_next, pred_taken_F, btb_hit_F, ghr_F, flush, pc_restore};
      want = sb.pop_front();
      nm   = sb_name.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL %s: got nxt=%h tk=%b hit=%b ghr=%h fl=%b rst=%h, need nxt=%h tk=%b hit=%b ghr=%h fl=%b rst=%h",
                 nm, got.nxt, got.tk, got.hit, got.ghr, got.fl, got.rst,
                 want.nxt, want.tk, want.hit, want.ghr, want.fl, want.rst);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t  got, want;
    string nm;
    for (int ph = 0; ph < 3; ph++) begin
      if (ph == 0) begin
        @(negedge clk);
        drive(mk_idle(32'h1004, 1'b1));
        sb.push_back(mk_exp(32'h740, 1'b1, 1'b1, 8'h33, 1'b0, 32'h0));
        #1;
      end else if (ph == 1) begin
        rst_n = 1'b0;
        sb.push_back(mk_exp(32'h1008, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0));
        #1;
      end else begin
        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back(mk_exp(32'h1008, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0));
        #2;
      end
      sb_name.push_back($sformatf("reset_mid_%0d", ph));
      got  = {pc_next, pred_taken_F, btb_hit_F, ghr_F, flush, pc_restore};
      want = sb.pop_front();
      nm   = sb_name.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("[TB] FAIL %s: got nxt=%h tk=%b hit=%b ghr=%h fl=%b rst=%h, need nxt=%h tk=%b hit=%b ghr=%h fl=%b rst=%h",
                 nm, got.nxt, got.tk, got.hit, got.ghr, got.fl, got.rst,
                 want.nxt, want.tk, want.hit, want.ghr, want.fl, want.rst);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(mk_idle(32'h100, 1'b1));
    test_reset();
    test_jump();
    test_branch_train();
    test_mispredict();
    test_saturation();
    test_alias();
    test_branch_and_jump();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
